// File: rtl/mem_master_pkg.sv
// Shared types for the load/store engine: access size encodings, FSM states
// and the alignment rule applied to every incoming request.
package mem_master_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  // Halfwords need an even byte address and words need a 4-byte aligned one.
  function automatic logic misaligned(size_e size, logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_master_lsu_if.sv
// Core-side request/response handshake plus the RAM port of the load/store
// engine; master is the engine's view, slave is the core-plus-RAM view.
interface mem_master_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        mem_en;
  logic        mem_wr;
  logic [31:0] addr;
  logic [31:0] data_rd;
  logic [31:0] data_wr;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, data_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_en, mem_wr, addr, data_wr
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, data_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_en, mem_wr, addr, data_wr
  );

endinterface

// File: rtl/mem_master_lsu_lane_align.sv
// Byte-lane steering: merges sub-word store data into the old RAM word and
// extracts/extends load data from a RAM word.
module lane_align
  import mem_master_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [31:0] shifted;

  assign byte_shift = {offset, 3'b000};
  assign half_shift = {offset[1], 4'b0000};
  assign shifted    = old_word >> byte_shift;

  // NOTE: every output gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    merged    = old_word;
    load_data = '0;
    case (size)
      SZ_BYTE: begin
        merged    = (old_word & ~(32'h0000_00FF << byte_shift))
                  | ({24'h0, new_data[7:0]} << byte_shift);
        load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        merged    = (old_word & ~(32'h0000_FFFF << half_shift))
                  | ({16'h0, new_data[15:0]} << half_shift);
        load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        merged    = new_data;
        load_data = old_word;
      end
      default: begin
        merged    = old_word;
        load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_master_lsu.sv
// Load/store engine between the core memory stage and a single-port RAM
// without byte enables; sub-word stores are done as read-modify-write.
module mem_master_lsu
  import mem_master_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_master_lsu_if.master bus
);

  state_e              state_q;
  state_e              state_d;

  logic                we_q;
  logic                uns_q;
  size_e               size_q;
  logic [AWIDTH+1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [DWIDTH-1:0]   rd_q;
  logic [DWIDTH-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  size_e               req_size;
  logic                req_err;
  logic                req_fire;
  logic [31:0]         word_idx;
  logic [31:0]         lane_old;
  logic [31:0]         merged;
  logic [31:0]         load_data;

  assign req_size = size_e'(bus.req_size);
  assign req_fire = (state_q == IDLE) && bus.req_valid;
  assign req_err  = (req_size == SZ_RSVD)
                 || misaligned(req_size, bus.req_addr[1:0])
                 || ((bus.req_addr >> (AWIDTH + 2)) != '0);
  assign word_idx = {{(32 - AWIDTH){1'b0}}, addr_q[AWIDTH+1:2]};

  // Loads extract straight from the RAM during READ so the response register is
  // loaded at the same edge that captures rd_q; WRITE merges into the captured word.
  assign lane_old = (state_q == READ) ? bus.data_rd : rd_q;

  lane_align u_lane_align (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .old_word    (lane_old),
    .new_data    (wdata_q),
    .merged      (merged),
    .load_data   (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)                                 state_d = RESP;
          else if (bus.req_we && req_size == SZ_WORD)  state_d = WRITE;
          else                                         state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: request fields and read capture carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      size_q  <= req_size;
      addr_q  <= bus.req_addr[AWIDTH+1:0];
      wdata_q <= bus.req_wdata;
    end
    if (state_q == READ) rd_q <= bus.data_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= req_err;
          end
        end
        READ: begin
          if (!we_q) rsp_rdata_q <= load_data;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Strobes are masked by rst so a store interrupted mid-RMW never commits at the reset edge.
  always_comb begin
    bus.mem_en  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.addr    = '0;
    bus.data_wr = '0;
    if (!rst) begin
      case (state_q)
        READ: begin
          bus.mem_en  = 1'b1;
          bus.addr    = word_idx;
          bus.data_wr = bus.data_rd;
        end
        WRITE: begin
          bus.mem_en  = 1'b1;
          bus.mem_wr  = 1'b1;
          bus.addr    = word_idx;
          bus.data_wr = merged;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master_lsu.sv
// Bench for mem_master_lsu: RAM responder plus a byte-array reference model
// driving directed and random loads/stores.
module tb_mem_master_lsu;
  import mem_master_pkg::*;

  localparam int AWIDTH = 8;
  localparam int NWORDS = 1 << AWIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_master_lsu_if bus ();

  mem_master_lsu #(.AWIDTH(AWIDTH), .DWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [31:0] ram     [NWORDS];
  logic [31:0] ref_mem [NWORDS];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_data = 32'h0;

  assign bus.data_rd = bus.mem_en ? ram[bus.addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (pre_we)                         ram[pre_idx]       <= pre_data;
    else if (bus.mem_en && bus.mem_wr)  ram[bus.addr[7:0]] <= bus.data_wr;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   32'(bus.rsp_err), 32'd0);
    check({tag, "_mem_en"},    32'(bus.mem_en), 32'd0);
    check({tag, "_mem_wr"},    32'(bus.mem_wr), 32'd0);
    check({tag, "_addr"},      bus.addr, 32'd0);
    check({tag, "_data_wr"},   bus.data_wr, 32'd0);
  endtask

  // Reference behaviour: memory as four bytes per word, result by byte picking.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic err, output logic [31:0] rdata,
                                output int lat, output logic [31:0] new_word);
    logic [7:0]  b [4];
    logic [31:0] w;
    logic [15:0] h;
    int          off;
    off      = int'(a[1:0]);
    err      = (size == 2'b11) || (size == SZ_HALF && a[0]) ||
               (size == SZ_WORD && off != 0) || (a >= 32'(NWORDS * 4));
    rdata    = 32'h0;
    new_word = 32'h0;
    lat      = 1;
    if (err) return;
    w = ref_mem[a[9:2]];
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    if (!we) begin
      lat = 2;
      if (size == SZ_BYTE)      rdata = uns ? {24'h0, b[off]} : {{24{b[off][7]}}, b[off]};
      else if (size == SZ_HALF) begin
        h     = {b[off+1], b[off]};
        rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
      end else                  rdata = w;
    end else if (size == SZ_WORD) begin
      lat      = 2;
      new_word = wd;
    end else begin
      lat    = 3;
      b[off] = wd[7:0];
      if (size == SZ_HALF) b[off+1] = wd[15:8];
      new_word = {b[3], b[2], b[1], b[0]};
    end
  endfunction

  // Called right after a negedge with the engine idle; returns at a negedge, idle again.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] new_word;
    logic [31:0] exp_idx;
    int          exp_lat;
    int          lat;
    int          n_en;
    int          n_wr;
    model(we, size, uns, a, wd, exp_err, exp_rdata, exp_lat, new_word);
    exp_idx = {24'h0, a[9:2]};
    check("req_ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    bus.rsp_ready    = (hold == 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat  = 0;
    n_en = 0;
    n_wr = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = c;
        break;
      end
      if (bus.mem_en) begin
        n_en++;
        check("mem_addr", bus.addr, exp_idx);
        if (bus.mem_wr) check("mem_wdata", bus.data_wr, new_word);
        else            check("mem_rd_rewrite", bus.data_wr, ref_mem[a[9:2]]);
      end
      if (bus.mem_wr) n_wr++;
    end
    check("latency",     32'(lat), 32'(exp_lat));
    check("mem_en_cnt",  32'(n_en), 32'(exp_lat - 1));
    check("mem_wr_cnt",  32'(n_wr), (we && !exp_err) ? 32'd1 : 32'd0);
    check("rsp_err",     32'(bus.rsp_err), 32'(exp_err));
    check("rsp_rdata",   bus.rsp_rdata, exp_rdata);
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_rdata", bus.rsp_rdata, exp_rdata);
      check("bp_rsp_err",   32'(bus.rsp_err), 32'(exp_err));
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_mem_en",    32'(bus.mem_en), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    if (we && !exp_err) ref_mem[a[9:2]] = new_word;
  endtask

  initial begin
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    int          r_sel;
    int          r_hold;

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b1;

    // Preload RAM and reference with the same random contents while in reset.
    for (int i = 0; i < NWORDS; i++) begin
      @(negedge clk);
      pre_we     = 1'b1;
      pre_idx    = 8'(i);
      pre_data   = $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Word store then load.
    run_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0);
    // Byte store read-modify-write.
    run_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1122_3344, 0);
    run_req(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h0000_00AA, 0);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 0);
    // Sign/zero extension.
    run_req(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h8000_FF80, 0);
    run_req(1'b0, SZ_BYTE, 1'b0, 32'h30, 32'h0, 0);
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h30, 32'h0, 0);
    run_req(1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0, 0);
    run_req(1'b0, SZ_HALF, 1'b1, 32'h32, 32'h0, 0);
    run_req(1'b1, SZ_HALF, 1'b0, 32'h32, 32'h1234_5678, 0);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 0);
    // Errors: misaligned, out of range, reserved size.
    run_req(1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0, 0);
    run_req(1'b0, SZ_HALF, 1'b0, 32'h41, 32'h0, 0);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, 0);
    run_req(1'b0, SZ_RSVD, 1'b0, 32'h0, 32'h0, 0);
    run_req(1'b1, SZ_WORD, 1'b0, 32'h13, 32'hFFFF_FFFF, 0);
    run_req(1'b1, SZ_BYTE, 1'b0, 32'h8000_0000, 32'h77, 0);
    // Backpressure on the response.
    run_req(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 5);
    run_req(1'b1, SZ_BYTE, 1'b0, 32'h23, 32'h0000_0099, 5);

    // Reset during the WRITE cycle of a byte store.
    bus.req_we       = 1'b1;
    bus.req_size     = SZ_BYTE;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h22;
    bus.req_wdata    = 32'h55;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rmw_read_en", 32'(bus.mem_en), 32'd1);
    check("rmw_read_wr", 32'(bus.mem_wr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rmw_rst_en", 32'(bus.mem_en), 32'd0);
    check("rmw_rst_wr", 32'(bus.mem_wr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rmw_reset");
    check("rmw_ram_unchanged", ram[8'h08], ref_mem[8'h08]);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 0);
    run_req(1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h55, 0);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 0);

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      r_size = 2'($urandom_range(0, 3));
      r_sel  = int'($urandom_range(0, 9));
      if (r_sel == 0) r_addr = $urandom;
      else            r_addr = 32'($urandom_range(0, NWORDS * 4 - 1));
      if (r_sel > 2) begin
        if (r_size == SZ_HALF)      r_addr[0]   = 1'b0;
        else if (r_size == SZ_WORD) r_addr[1:0] = 2'b00;
      end
      r_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_req(1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)),
              r_addr, $urandom, r_hold);
    end

    for (int i = 0; i < NWORDS; i++) begin
      if (ram[i] !== ref_mem[i]) check("ram_final", ram[i], ref_mem[i]);
    end
    check("ram_final_word20", ram[8'h08], ref_mem[8'h08]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_master_lsu.md
# mem_master_lsu

Initiator-side load/store engine that drives the single-port data RAM on behalf of the core. It accepts one byte/halfword/word load or store per request over a valid/ready handshake, converts byte addresses to RAM word indices, and performs read-modify-write for sub-word stores because the RAM has no byte enables. It returns sign- or zero-extended load data, or an error for misaligned or out-of-range accesses. It sits between the core's memory stage and the RAM port.

## Interface
- AWIDTH, 8, RAM word-address bits; must equal the attached RAM's AWIDTH
- DWIDTH, 32, data width; only 32 is supported
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  engine can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (error)
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or reserved size
- mem_en  out  1  RAM access strobe
- mem_wr  out  1  RAM write strobe, only with mem_en
- addr  out  32  word index = {zeros, req_addr[AWIDTH+1:2]}
- data_rd  in  32  RAM read data, combinational from addr while mem_en
- data_wr  out  32  RAM write data

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) latches all req_* fields. Error check: size 11; half with addr[0]≠0; word with addr[1:0]≠0; any of addr[31:AWIDTH+2]≠0. Error → RESP with rsp_err=1 and no RAM access. Otherwise load → READ, word store → WRITE, byte/half store → READ.
- READ: mem_en=1, mem_wr=0, data_wr=data_rd, so a responder that commits on any enable rewrites the same word. data_rd is captured into rd_q at the edge. Next state is RESP for loads and WRITE for stores.
- WRITE: mem_en=1, mem_wr=1. data_wr is req_wdata for word stores. For sub-word stores it is rd_q with the selected lane replaced: byte lane addr[1:0], half lane addr[1]. Next state is RESP.
- Load extract: shift rd_q right by 8·addr[1:0], mask to size, then extend per req_unsigned.
- RESP: rsp_valid=1. Outputs hold stable until rsp_ready; the handshake → IDLE. A new request cannot be accepted in the same cycle as a response handshake.
- Outside READ/WRITE: mem_en=0, mem_wr=0, addr=0, data_wr=0.
- Reset in any state: return to IDLE and drop the in-flight request. A sub-word store interrupted between READ and WRITE leaves the RAM unmodified.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_wr=0, addr=0, data_wr=0.
- Request accepted at edge 0. Cycle counts below run until rsp_valid rises, with rsp_ready held high:
  - load: 2 cycles (READ in cycle 1, RESP in cycle 2)
  - word store: 2 cycles (WRITE, RESP)
  - sub-word store: 3 cycles (READ, WRITE, RESP)
  - error: 1 cycle
- Throughput: one request per latency+1 cycles; there is no pipelining.
- The RAM write commits at the edge ending the WRITE cycle.
- Response outputs are registered. Memory outputs are a combinational decode of state plus latched fields.

## Structure
- Package mem_master_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - the state enum IDLE/READ/WRITE/RESP
  - function for misalignment check
- Sub-module lane_align (combinational) does store lane merge and load extract/extend. It takes size, offset, unsigned, old word and new data, and returns merged word and load result.

## Test plan
- Word store then load: store 0xDEADBEEF @0x10, then load word @0x10. Expect addr=4, mem_wr pulse one cycle, rsp_rdata=0xDEADBEEF, rsp_err=0, latency 2.
- Byte store RMW: word @0x20 = 0x11223344, then store byte 0xAA @0x21. Expect a READ then WRITE cycle with data_wr=0x1122AA44, latency 3.
- Extension: word @0x30 = 0x8000FF80. Load signed byte @0x30 → 0xFFFFFF80. Load unsigned byte @0x30 → 0x00000080. Load signed half @0x32 → 0xFFFF8000.
- Errors: load word @0x02 and load half @0x41 → rsp_err=1, mem_en never high, latency 1. With AWIDTH=8, load @0x400 → rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid/rsp_rdata stay stable, req_ready=0, and no RAM access occurs.
- Reset mid-RMW: assert rst in the cycle after READ of a byte store. Expect the RAM word unchanged, all outputs at reset values next cycle, and the next request serviced normally.
